// File: rtl/feature_channel_scheduler.sv
// feature_channel_scheduler
// Round-robin scheduler that time-shares one abs-difference spike-feature
// datapath among NUM_CH sample requesters. Each accepted sample is
// differenced against the sample two positions earlier on the same channel.
// The difference is then compared against a runtime threshold. One tagged
// result is produced per accepted sample, two cycles after acceptance.
//
// Optional build macro: FEATURE_SCHED_REFRACT_EN
//   When it is defined, each channel gets a refractory counter. After a
//   reported hit, that counter suppresses further hits on the same channel
//   for REFRACT_CYC cycles.
module feature_channel_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 16,
    parameter int REFRACT_CYC = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH*DATA_W-1:0]    req_data,
    output logic [NUM_CH-1:0]           req_ack,
    input  logic                        cfg_enable,
    input  logic [NUM_CH-1:0]           cfg_ch_mask,
    input  logic [DATA_W-1:0]           cfg_thresh,
    output logic                        det_valid,
    output logic [$clog2(NUM_CH)-1:0]   det_ch,
    output logic                        det_hit
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int DW1  = DATA_W + 1;

    // Arbitration signals
    logic [NUM_CH-1:0]          w_elig;
    logic [NUM_CH-1:0]          w_grant;
    logic                       w_grant_any;
    logic [CH_W-1:0]            w_grant_idx;
    logic [CH_W-1:0]            w_cand;
    logic [CH_W-1:0]            r_ptr;

    // Per-channel sample view and history
    logic signed [DATA_W-1:0]   w_sample [NUM_CH];
    logic signed [DATA_W-1:0]   r_h0     [NUM_CH];
    logic signed [DATA_W-1:0]   r_h1     [NUM_CH];
    logic [1:0]                 r_warm   [NUM_CH];

    // Stage 1 registers
    logic                       r_v1;
    logic [CH_W-1:0]            r_ch1;
    logic                       r_warm_ok1;
    logic signed [DW1-1:0]      r_diff;

    // Datapath wires
    logic signed [DATA_W-1:0]   w_sel_sample;
    logic signed [DATA_W-1:0]   w_sel_h1;
    logic signed [DW1-1:0]      w_diff;
    logic                       w_gt;
    logic                       w_hit_raw;
    logic                       w_suppress;

    // Unpack the flat sample bus into one signed lane per channel
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_sample[gi] = $signed(req_data[gi*DATA_W +: DATA_W]);
        end
    endgenerate

    // Grants are suppressed during reset, so req_ack is 0 while rst is high
    assign w_elig  = req & cfg_ch_mask & {NUM_CH{cfg_enable & ~rst}};
    assign req_ack = w_grant;

    // Round-robin search that starts one past the last granted channel
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = CH_W'((int'(r_ptr) + k) % NUM_CH);
            if (!w_grant_any && w_elig[w_cand]) begin
                w_grant[w_cand] = 1'b1;
                w_grant_any     = 1'b1;
                w_grant_idx     = w_cand;
            end
        end
    end

    // Select the granted channel's sample and its sample from two accepts ago.
    // Both are sign-extended to 17 bits, so the difference cannot overflow.
    always_comb begin
        w_sel_sample = w_sample[w_grant_idx];
        w_sel_h1     = r_h1[w_grant_idx];
        w_diff       = $signed({w_sel_sample[DATA_W-1], w_sel_sample})
                     - $signed({w_sel_h1[DATA_W-1], w_sel_h1});
    end

    // The pointer advances only when a grant is issued; after reset channel 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= CH_W'(NUM_CH - 1);
        end else if (w_grant_any) begin
            r_ptr <= w_grant_idx;
        end
    end

    // Stage 1: update history on the accept edge and register the difference
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_h0[i]   <= '0;
                r_h1[i]   <= '0;
                r_warm[i] <= 2'd0;
            end
            r_v1       <= 1'b0;
            r_ch1      <= '0;
            r_warm_ok1 <= 1'b0;
            r_diff     <= '0;
        end else begin
            r_v1  <= w_grant_any;
            r_ch1 <= w_grant_idx;
            if (w_grant_any) begin
                r_diff              <= w_diff;
                r_h0[w_grant_idx]   <= w_sel_sample;
                r_h1[w_grant_idx]   <= r_h0[w_grant_idx];
                r_warm_ok1          <= (r_warm[w_grant_idx] == 2'd2);
                if (r_warm[w_grant_idx] != 2'd2) begin
                    r_warm[w_grant_idx] <= r_warm[w_grant_idx] + 2'd1;
                end
            end
        end
    end

    // Only positive excursions above the unsigned threshold count as crossings
    assign w_gt      = (r_diff > $signed({1'b0, cfg_thresh}));
    assign w_hit_raw = r_v1 & r_warm_ok1 & w_gt;

`ifdef FEATURE_SCHED_REFRACT_EN
    logic [NUM_CH-1:0][7:0] r_refr;

    assign w_suppress = (r_refr[r_ch1] != 8'd0);

    // A hit that is actually reported reloads its channel's counter. A load
    // takes priority over the countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refr <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hit_raw && !w_suppress && (r_ch1 == CH_W'(i))) begin
                    r_refr[i] <= 8'(REFRACT_CYC);
                end else if (r_refr[i] != 8'd0) begin
                    r_refr[i] <= r_refr[i] - 8'd1;
                end
            end
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    // Stage 2: tagged result strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            det_valid <= 1'b0;
            det_ch    <= '0;
            det_hit   <= 1'b0;
        end else begin
            det_valid <= r_v1;
            det_ch    <= r_ch1;
            det_hit   <= w_hit_raw & ~w_suppress;
        end
    end

endmodule

// File: tb/tb_feature_channel_scheduler.sv
// Directed testbench for feature_channel_scheduler (NUM_CH=4, DATA_W=16).
// It builds against both settings of FEATURE_SCHED_REFRACT_EN.
module tb_feature_channel_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  req_ack;
    logic        cfg_enable;
    logic [3:0]  cfg_ch_mask;
    logic [15:0] cfg_thresh;
    logic        det_valid;
    logic [1:0]  det_ch;
    logic        det_hit;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_cyc;

    int q_ch[$];
    int q_hit[$];
    int q_cyc[$];

    feature_channel_scheduler #(
        .NUM_CH(4), .DATA_W(16), .REFRACT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
        .cfg_enable(cfg_enable), .cfg_ch_mask(cfg_ch_mask), .cfg_thresh(cfg_thresh),
        .det_valid(det_valid), .det_ch(det_ch), .det_hit(det_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log each result, one line per transaction
    always @(negedge clk) begin
        if (det_valid === 1'b1) begin
            q_ch.push_back(int'(det_ch));
            q_hit.push_back(int'(det_hit));
            q_cyc.push_back(cyc);
            $display("det ch=%0d hit=%0d cyc=%0d", det_ch, det_hit, cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_ch.delete();
        q_hit.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
    endtask

    task automatic flush();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Present one sample on a channel and hold the request until it is accepted
    task automatic send(input int ch, input logic [15:0] v);
        int n = 0;
        req_data[ch*16 +: 16] = v;
        req[ch] = 1'b1;
        #1;
        while (req_ack[ch] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ack[ch] !== 1'b1) chk("ack_timeout", 0, 1);
        @(posedge clk); #1;
        req[ch] = 1'b0;
    endtask

    // Compare the logged results against hand-computed hit bits and one channel
    task automatic check_results(input string tag, input int n, input logic [15:0] hits, input int ch);
        chk({tag, "_count"}, q_hit.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < q_hit.size()) begin
                chk($sformatf("%s_hit%0d", tag, k), q_hit[k], int'(hits[k]));
                chk($sformatf("%s_ch%0d", tag, k), q_ch[k], ch);
            end else begin
                chk($sformatf("%s_missing%0d", tag, k), -1, int'(hits[k]));
            end
        end
    endtask

    logic [3:0]  rr_exp [5];
    logic [15:0] ramp_exp;

    initial begin
        req         = 4'b0000;
        req_data    = '0;
        cfg_enable  = 1'b1;
        cfg_ch_mask = 4'b1111;
        cfg_thresh  = 16'd0;
        rst         = 1'b1;

        // Reset state, with every channel requesting
        req = 4'b1111;
        @(posedge clk); #1;
        chk("rst_ack", int'(req_ack), 0);
        chk("rst_valid", int'(det_valid), 0);
        chk("rst_hit", int'(det_hit), 0);
        chk("rst_ch", int'(det_ch), 0);
        rst = 1'b0;
        clear_log();

        // Mask and enable gating, evaluated before any clock edge
        cfg_ch_mask = 4'b1010; #1;
        chk("mask_ack", int'(req_ack), 4'b0010);
        cfg_enable = 1'b0; #1;
        chk("disable_ack", int'(req_ack), 0);
        cfg_enable = 1'b1; cfg_ch_mask = 4'b1111; #1;

        // Round-robin across all four channels
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        ack_cyc = cyc;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_ack%0d", k), int'(req_ack), int'(rr_exp[k]));
            @(posedge clk); #1;
        end
        req = 4'b0000;
        flush();
        chk("rr_count", q_ch.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < q_ch.size()) chk($sformatf("rr_ch%0d", k), q_ch[k], k % 4);
        end
        if (q_cyc.size() > 0) chk("rr_latency", q_cyc[0] - ack_cyc, 2);
        else chk("rr_latency_none", -1, 2);

        // Threshold crossing on channel 0: samples 0, 0, 600 give hits 0, 0, 1
        do_reset();
        cfg_thresh = 16'd500;
        send(0, 16'd0); send(0, 16'd0); send(0, 16'd600);
        flush();
        check_results("cross", 3, 16'b100, 0);

        // A difference equal to the threshold does not count as a hit
        do_reset();
        send(0, 16'd100); send(0, 16'd200); send(0, 16'd600);
        send(0, 16'd700); send(0, 16'd1300);
        flush();
        check_results("equal", 5, 16'b10000, 0);

        // Warm-up at the extremes; the third sample gives 32767-(-32768)=65535
        do_reset();
        cfg_thresh = 16'd0;
        send(2, 16'h8000); send(2, 16'h7FFF); send(2, 16'h7FFF);
        flush();
        check_results("warm", 3, 16'b100, 2);

        // Channel 1 ramp: every sample after warm-up is a crossing
        do_reset();
        cfg_thresh = 16'd0;
        for (int k = 0; k < 12; k++) send(1, 16'(k * 10));
        flush();
`ifdef FEATURE_SCHED_REFRACT_EN
        ramp_exp = 16'b0000_1000_0000_0100;
`else
        ramp_exp = 16'b0000_1111_1111_1100;
`endif
        check_results("ramp", 12, ramp_exp, 1);

        // Reset while later samples are still in the pipeline
        do_reset();
        cfg_thresh = 16'd0;
        send(0, 16'd0); send(0, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", int'(det_valid), 0);
        flush();
        chk("midrst_count", q_hit.size(), 1);
        req = 4'b1111; #1;
        chk("midrst_ptr", int'(req_ack), 4'b0001);
        req = 4'b0000;
        clear_log();
        send(0, 16'd1000); send(0, 16'd2000); send(0, 16'd3000);
        flush();
        check_results("rewarm", 3, 16'b100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/feature_channel_scheduler.md
# feature_channel_scheduler

Time-multiplexed controller for the abs-difference spike feature: NUM_CH sample requesters share a single difference/threshold datapath. The block arbitrates round-robin among pending channel requests, keeps per-channel two-sample history, computes s[n] − s[n−2] and compares it against a runtime threshold. It emits one tagged detection result per accepted sample and sits between the per-electrode sample front-ends and the segmentation logic.

## Interface
- NUM_CH, 4: number of requesting channels (2–16).
- DATA_W, 16: sample width, signed two's complement.
- REFRACT_CYC, 8: refractory length in clock cycles (1–255).
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_CH  per-channel sample request; bit i holds until acked.
- req_data  input  NUM_CH*DATA_W  packed samples; channel i at [i*DATA_W +: DATA_W].
- req_ack  output  NUM_CH  one-hot (or zero) combinational grant; sample accepted on the edge where req[i] & req_ack[i].
- cfg_enable  input  1  when low, no grants are issued; in-flight results still drain.
- cfg_ch_mask  input  NUM_CH  channel i eligible only when bit set.
- cfg_thresh  input  DATA_W  unsigned threshold, sampled at stage 2.
- det_valid  output  1  result strobe, one cycle per accepted sample.
- det_ch  output  clog2(NUM_CH)  channel of the result.
- det_hit  output  1  threshold crossing flag, qualified by det_valid.

## Operation
- Arbitration: eligible = req & cfg_ch_mask, gated by cfg_enable. Search starts at ptr+1 modulo NUM_CH; the first eligible channel is granted. At most one grant per cycle. ptr updates to the granted index only on a grant. ptr resets to NUM_CH−1, so channel 0 has priority first.
- Per-channel state:
  - h0 and h1: last and previous accepted samples, DATA_W signed.
  - warm: 2-bit count of accepted samples, saturating at 2.
- Stage 1, on the accept edge:
  - diff_r <= sext17(sample) − sext17(h1[ch]).
  - h1 <= h0 and h0 <= sample.
  - Capture v1, ch1 and warm_ok1 = (warm[ch] == 2).
  - warm increments.
- Stage 2:
  - det_valid <= v1 and det_ch <= ch1.
  - det_hit <= v1 & warm_ok1 & (diff_r > signed {0, cfg_thresh}) & ~refractory-suppress.
- The difference is signed and only positive-going excursions count, so a negative diff never hits. Width is 17 bits and cannot overflow.
- Stage 1 and stage 2 run every cycle regardless of cfg_enable.
- Reset clears all history, warm counters, pipeline valids, ptr and refractory counters.

## Timing
- req_ack is combinational from req, cfg_ch_mask, cfg_enable and ptr, in the same cycle.
- Latency: a sample accepted at edge t produces det_valid high in the cycle after edge t+1 (2-cycle latency). Throughput is one sample per cycle.
- Back-to-back grants to the same channel are allowed when it is the only eligible channel. History forwarding is inherent because history updates on the accept edge.
- Reset values: det_valid=0, det_hit=0, det_ch=0. req_ack=0 while rst is high.
- Reset asserted mid-operation discards in-flight results; no det_valid is issued for them.
- Deasserting cfg_enable mid-stream leaves already-accepted samples to complete normally.
- Deasserting a cfg_ch_mask bit removes that channel from arbitration on the next evaluation; its history is retained.

## Configuration
- FEATURE_SCHED_REFRACT_EN defined:
  - Each channel has an 8-bit refractory counter.
  - When det_hit would be 1 for channel c, the counter for c loads REFRACT_CYC. While it is nonzero, hits on c are forced to 0, but det_valid is still issued.
  - Counters decrement every cycle while nonzero. A load on the same cycle as a decrement takes the load.
- FEATURE_SCHED_REFRACT_EN undefined: no counters exist and every qualifying crossing reports det_hit=1.

## Test plan
- Reset, then req=4'b1111 held with all masks set → req_ack sequence 0001, 0010, 0100, 1000, 0001; det_ch sequence 0,1,2,3 starting 2 cycles after the first ack.
- Channel 0 only, samples 0, 0, 600 with cfg_thresh=500 → det_hit 0, 0, 1; the third hit has diff 600 > 500.
- Channel 0 samples 100, 200, 600 with cfg_thresh=500 → diff = 600 − 100 = 500, not greater, so det_hit=0. Next sample 700 → 700 − 200 = 500, det_hit=0. Next sample 1300 → 1300 − 600 = 700, det_hit=1.
- Warm-up: the first two samples on a fresh channel, values −32768 then 32767 with cfg_thresh=0 → det_hit=0 both times.
- FEATURE_SCHED_REFRACT_EN with REFRACT_CYC=8, channel 1 crossing every cycle → det_hit=1, then 0 for samples accepted during the 8 refractory cycles, then 1 again.
- Assert rst for 1 cycle with 2 samples in flight → no det_valid afterwards, ptr restarts at channel 0, and the next channel's warm-up restarts.
